// File: rtl/elink_word_aligner.sv
// elink_word_aligner
//   Fabric-side e-link word aligner on the divided SERDES clock.
//   RX: collects LANE_W-bit lanes, hunts for SYNC_PATTERN at every bit offset,
//       verifies SYNC_COUNT aligned syncs, then delivers aligned words.
//   TX: serialises WORD_W-bit words into LANE_W-bit lanes, MSB lane first,
//       filling idle slots with SYNC_PATTERN.
//   Optional build macro ELINK_LOOPBACK_EN adds a `loopback` input that feeds
//   the registered tx_lane back into the RX shift register.
// Ports:
//   clk, reset (async, active-low)
//   rx_lane, rx_realign                        : RX lane in, force re-hunt
//   rx_data, rx_valid, rx_is_sync, rx_locked   : aligned word output
//   realign_cnt                                : saturating LOCKED->HUNT count
//   tx_data, tx_valid, tx_ready, tx_lane       : TX word in, lane out
//
// state    | meaning
// ---------+------------------------------------------------------------
// HUNT     | scanning every offset each cycle for SYNC_PATTERN
// VERIFY   | offset chosen, checking consecutive syncs at word boundaries
// LOCKED   | delivering aligned words, watching for loss of sync
module elink_word_aligner #(
  parameter int unsigned       LANE_W       = 2,
  parameter int unsigned       WORD_W       = 8,
  parameter logic [WORD_W-1:0] SYNC_PATTERN = 8'hBC,
  parameter int unsigned       SYNC_COUNT   = 4,
  parameter int unsigned       LOSS_WORDS   = 256
) (
  input  logic              clk,
  input  logic              reset,
`ifdef ELINK_LOOPBACK_EN
  input  logic              loopback,
`endif
  input  logic [LANE_W-1:0] rx_lane,
  input  logic              rx_realign,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_is_sync,
  output logic              rx_locked,
  output logic [7:0]        realign_cnt,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [LANE_W-1:0] tx_lane
);

  localparam int unsigned SH_W   = WORD_W + LANE_W - 1;
  localparam int unsigned NLANES = WORD_W / LANE_W;
  localparam int unsigned PH_W   = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam int unsigned OFF_W  = (LANE_W > 1) ? $clog2(LANE_W) : 1;
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(NLANES - 1);
  localparam logic [15:0]     SYNC_LIM = 16'(SYNC_COUNT);
  localparam logic [15:0]     LOSS_LIM = 16'(LOSS_WORDS);
  localparam logic            LOSS_EN  = (LOSS_WORDS != 0);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [SH_W-1:0]   shreg_q, shreg_d;
  logic [OFF_W-1:0]  bit_off_q, bit_off_d;
  logic [PH_W-1:0]   lane_ph_q, lane_ph_d;
  logic [15:0]       sync_cnt_q, sync_cnt_d;
  logic [15:0]       loss_cnt_q, loss_cnt_d;
  logic [7:0]        realign_cnt_q, realign_cnt_d;
  logic [WORD_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_is_sync_q, rx_is_sync_d;
  logic [WORD_W-1:0] tx_sh_q, tx_sh_d;
  logic [PH_W-1:0]   tx_ph_q, tx_ph_d;
  logic [LANE_W-1:0] tx_lane_q, tx_lane_d;

  logic [LANE_W-1:0] lane_in;
  logic              force_hunt;
  logic              hit;
  logic [OFF_W-1:0]  hit_off;
  logic [WORD_W-1:0] word_at_off;
  logic              word_sync;
  logic              boundary;

`ifdef ELINK_LOOPBACK_EN
  logic loopback_q;
  assign lane_in    = loopback ? tx_lane_q : rx_lane;
  // Changing the RX source invalidates any alignment found so far.
  assign force_hunt = rx_realign | (loopback ^ loopback_q);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) loopback_q <= 1'b0;
    else        loopback_q <= loopback;
  end
`else
  assign lane_in    = rx_lane;
  assign force_hunt = rx_realign;
`endif

  // Newest bit lands at index 0; lane bit LANE_W-1 is the earliest received.
  assign shreg_d     = {shreg_q[SH_W-LANE_W-1:0], lane_in};
  assign word_at_off = shreg_q[bit_off_q +: WORD_W];
  assign word_sync   = (word_at_off == SYNC_PATTERN);
  assign boundary    = (lane_ph_q == PH_LAST);

  // Scan from the highest offset down so the lowest matching offset wins.
  always_comb begin
    hit     = 1'b0;
    hit_off = '0;
    for (int b = int'(LANE_W) - 1; b >= 0; b--) begin
      if (shreg_q[b +: WORD_W] == SYNC_PATTERN) begin
        hit     = 1'b1;
        hit_off = OFF_W'(b);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_off_d     = bit_off_q;
    lane_ph_d     = boundary ? '0 : lane_ph_q + 1'b1;
    sync_cnt_d    = sync_cnt_q;
    loss_cnt_d    = loss_cnt_q;
    realign_cnt_d = realign_cnt_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    rx_is_sync_d  = rx_is_sync_q;
    if (force_hunt) begin
      state_d    = ST_HUNT;
      sync_cnt_d = '0;
      loss_cnt_d = '0;
      if (state_q == ST_LOCKED && realign_cnt_q != 8'hFF)
        realign_cnt_d = realign_cnt_q + 8'd1;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (hit) begin
            bit_off_d  = hit_off;
            lane_ph_d  = '0;
            sync_cnt_d = 16'd1;
            loss_cnt_d = '0;
            state_d    = (SYNC_LIM <= 16'd1) ? ST_LOCKED : ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (boundary) begin
            if (word_sync) begin
              sync_cnt_d = sync_cnt_q + 16'd1;
              if (sync_cnt_q + 16'd1 >= SYNC_LIM) state_d = ST_LOCKED;
            end else begin
              sync_cnt_d = '0;
              state_d    = ST_HUNT;
            end
          end
        end
        ST_LOCKED: begin
          if (boundary) begin
            rx_data_d    = word_at_off;
            rx_valid_d   = 1'b1;
            rx_is_sync_d = word_sync;
            if (word_sync) begin
              loss_cnt_d = '0;
            end else if (LOSS_EN && (loss_cnt_q + 16'd1 == LOSS_LIM)) begin
              loss_cnt_d = '0;
              sync_cnt_d = '0;
              state_d    = ST_HUNT;
              if (realign_cnt_q != 8'hFF) realign_cnt_d = realign_cnt_q + 8'd1;
            end else if (loss_cnt_q != 16'hFFFF) begin
              loss_cnt_d = loss_cnt_q + 16'd1;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // TX: the lane leaving the shift register this cycle is registered onto
  // tx_lane; the next word is loaded as the last lane of the current one leaves.
  assign tx_ready  = (tx_ph_q == PH_LAST);
  assign tx_lane_d = tx_sh_q[WORD_W-1 -: LANE_W];
  assign tx_ph_d   = tx_ready ? '0 : tx_ph_q + 1'b1;
  assign tx_sh_d   = tx_ready ? (tx_valid ? tx_data : SYNC_PATTERN)
                              : (tx_sh_q << LANE_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_HUNT;
      shreg_q       <= '0;
      bit_off_q     <= '0;
      lane_ph_q     <= '0;
      sync_cnt_q    <= '0;
      loss_cnt_q    <= '0;
      realign_cnt_q <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_is_sync_q  <= 1'b0;
      tx_sh_q       <= SYNC_PATTERN;
      tx_ph_q       <= '0;
      tx_lane_q     <= '0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_off_q     <= bit_off_d;
      lane_ph_q     <= lane_ph_d;
      sync_cnt_q    <= sync_cnt_d;
      loss_cnt_q    <= loss_cnt_d;
      realign_cnt_q <= realign_cnt_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_is_sync_q  <= rx_is_sync_d;
      tx_sh_q       <= tx_sh_d;
      tx_ph_q       <= tx_ph_d;
      tx_lane_q     <= tx_lane_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_is_sync  = rx_is_sync_q;
  assign rx_locked   = (state_q == ST_LOCKED);
  assign realign_cnt = realign_cnt_q;
  assign tx_lane     = tx_lane_q;

endmodule

// File: tb/tb_elink_word_aligner.sv
// Testbench for elink_word_aligner: randomized RX segments and TX words,
// expected words queued from a word-level model, popped by a monitor.
module tb_elink_word_aligner;

  localparam int LANE_W     = 2;
  localparam int WORD_W     = 8;
  localparam int SYNC_COUNT = 4;
  localparam int LOSS_WORDS = 4;
  localparam logic [7:0] SYNC = 8'hBC;
  localparam int NTX = 600;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] rx_lane;
  logic       rx_realign;
  logic [7:0] rx_data;
  logic       rx_valid, rx_is_sync, rx_locked;
  logic [7:0] realign_cnt;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [1:0] tx_lane;

  always #5 clk = ~clk;

  elink_word_aligner #(
    .LANE_W(LANE_W), .WORD_W(WORD_W), .SYNC_PATTERN(SYNC),
    .SYNC_COUNT(SYNC_COUNT), .LOSS_WORDS(LOSS_WORDS)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef ELINK_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .rx_lane(rx_lane),
    .rx_realign(rx_realign),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_is_sync(rx_is_sync),
    .rx_locked(rx_locked),
    .realign_cnt(realign_cnt),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_lane(tx_lane)
  );

  int checks = 0;
  int failures = 0;
  int exp_realign = 0;
  logic [7:0] exp_q[$];
  int cyc = 0;
  int last_valid = -1000;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected word per rx_valid strobe.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset === 1'b1 && rx_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_unexpected_valid actual=%0h expected=none", rx_data);
        end else begin
          logic [7:0] w;
          w = exp_q.pop_front();
          chk("rx_data", rx_data, w);
          chk("rx_is_sync", rx_is_sync, (w == SYNC));
        end
        if (cyc - last_valid < 12) chk("rx_valid_spacing", cyc - last_valid, 4);
        last_valid = cyc;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Word-level model: acquisition needs SYNC_COUNT consecutive syncs, locked
  // words are delivered, LOSS_WORDS consecutive non-syncs drop lock, and a
  // realign during word r restarts acquisition at word r.
  task automatic run_segment(int p, logic [7:0] words[$], int realign_word, bit gap_realign);
    bit locked = 0;
    int run = 0, loss = 0, fe = -1;
    bit bits[$];
    int nl, rlane, glane, lc, er;
    for (int i = 0; i < words.size(); i++) begin
      if (i == realign_word) begin
        if (locked) exp_realign++;
        locked = 0;
        run = 0;
      end
      if (!locked) begin
        if (words[i] == SYNC) begin
          run++;
          if (run == SYNC_COUNT) begin locked = 1; loss = 0; end
        end else run = 0;
      end else begin
        exp_q.push_back(words[i]);
        if (fe < 0) fe = i;
        if (words[i] == SYNC) loss = 0;
        else begin
          loss++;
          if (loss == LOSS_WORDS) begin locked = 0; run = 0; exp_realign++; end
        end
      end
    end
    for (int i = 0; i < p; i++) bits.push_back(1'b0);
    foreach (words[i]) for (int k = 7; k >= 0; k--) bits.push_back(words[i][k]);
    for (int i = 0; i < 16; i++) bits.push_back(1'b0);
    if (bits.size() % 2 != 0) bits.push_back(1'b0);
    nl    = bits.size() / 2;
    rlane = (realign_word >= 0) ? (p + 8 * realign_word - 1) / 2 + 2 : -1;
    glane = gap_realign ? (p + 8 * words.size()) / 2 + 4 : -1;
    lc    = (fe >= 0) ? (p + 8 * fe + 7) / 2 + 2 : -1;
    for (int n = 0; n < nl; n++) begin
      @(negedge clk);
      if (n == lc) chk("rx_locked_mid", rx_locked, 1);
      rx_lane    = {bits[2*n], bits[2*n+1]};
      rx_realign = (n == rlane) || (n == glane);
    end
    @(negedge clk);
    rx_realign = 1'b0;
    rx_lane    = 2'b00;
    er = (exp_realign > 255) ? 255 : exp_realign;
    chk("rx_locked_end", rx_locked, locked);
    chk("realign_cnt", realign_cnt, er);
  endtask

  task automatic rx_proc();
    logic [7:0] w[$];
    // b=1 offset, locked data words between syncs
    w = {SYNC, SYNC, SYNC, SYNC, SYNC, SYNC, 8'h5A, SYNC, 8'hC3, SYNC,
         8'h00, 8'h00, 8'h00, 8'h00};
    run_segment(1, w, -1, 1'b0);
    // corrupted 3rd sync during verify, realign pulse while hunting
    w = {SYNC, SYNC, 8'h00, SYNC, SYNC, SYNC, SYNC, SYNC};
    for (int g = 0; g < 2; g++) begin
      w.push_back(8'($urandom_range(0, 255)));
      w.push_back(8'($urandom_range(0, 255)));
      w.push_back(SYNC);
    end
    for (int i = 0; i < 4; i++) w.push_back(8'h00);
    run_segment($urandom_range(0, 7), w, -1, 1'b1);
    // realign while locked
    w.delete();
    for (int i = 0; i < 13; i++) w.push_back(SYNC);
    for (int i = 0; i < 4; i++) w.push_back(8'h00);
    run_segment($urandom_range(0, 7), w, 7, 1'b0);
    // random payload segments at random offsets
    for (int s = 0; s < 4; s++) begin
      w = {SYNC, SYNC, SYNC, SYNC};
      for (int g = 0; g < int'($urandom_range(1, 4)); g++) begin
        w.push_back(8'($urandom_range(0, 255)));
        w.push_back(8'($urandom_range(0, 255)));
        w.push_back(SYNC);
      end
      for (int i = 0; i < 4; i++) w.push_back(8'h00);
      run_segment($urandom_range(0, 7), w, -1, 1'b0);
    end
    // repeated loss of lock until realign_cnt saturates
    for (int s = 0; s < 300; s++) begin
      w = {SYNC, SYNC, SYNC, SYNC, 8'h00, 8'h00, 8'h00, 8'h00};
      run_segment($urandom_range(0, 7), w, -1, 1'b0);
    end
  endtask

  // TX: expected lanes queued as each word slot is filled, popped each cycle.
  task automatic tx_proc();
    logic [1:0] tq[$];
    logic [7:0] word;
    bit exp_ready;
    logic [1:0] exp_lane;
    for (int k = 3; k >= 0; k--) tq.push_back(2'(SYNC >> (2 * k)));
    for (int c = 0; c < NTX; c++) begin
      if (c > 0) @(negedge clk);
      exp_ready = (c % 4 == 3);
      chk("tx_ready", tx_ready, exp_ready);
      exp_lane = (c == 0) ? 2'b00 : tq.pop_front();
      chk("tx_lane", tx_lane, exp_lane);
      if (c < 8) begin
        tx_valid = 1'b1;
        tx_data  = (c < 4) ? 8'hA5 : 8'h3C;
      end else if (c < 16) begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
      end else begin
        tx_valid = 1'($urandom_range(0, 1));
        tx_data  = 8'($urandom_range(0, 255));
      end
      if (exp_ready) begin
        word = tx_valid ? tx_data : SYNC;
        for (int k = 3; k >= 0; k--) tq.push_back(2'(word >> (2 * k)));
      end
    end
    tx_valid = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    rx_lane    = 2'b00;
    rx_realign = 1'b0;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_rx_locked", rx_locked, 0);
    chk("reset_realign_cnt", realign_cnt, 0);
    chk("reset_tx_lane", tx_lane, 0);
    reset = 1'b1;
    fork
      tx_proc();
      rx_proc();
    join
    repeat (10) @(negedge clk);
    chk("rx_pending", exp_q.size(), 0);
    // asynchronous reset mid-operation
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("areset_realign_cnt", realign_cnt, 0);
    chk("areset_tx_lane", tx_lane, 0);
    chk("areset_rx_valid", rx_valid, 0);
    chk("areset_rx_data", rx_data, 0);
    chk("areset_tx_ready", tx_ready, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
